// File: rtl/dct_col_drain.sv
// Column drain between the 32x32 transpose buffer and the second DCT pass.
// Optional per-lane saturation and out_sat reporting: define ROUND_CLIP_SAT_EN (default build wraps instead).
module dct_col_drain #(
    parameter int IN_WIDTH  = 21,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 11,
    parameter int N         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      blk_full,
    output logic                      blk_take,
    input  logic [N*IN_WIDTH-1:0]     col_in,
    output logic                      unload,
    output logic [N*OUT_WIDTH-1:0]    out_data,
    output logic [$clog2(N)-1:0]      out_col,
    output logic                      out_last,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH+1)'(64'sd1 <<< (SHIFT - 1));
`ifdef ROUND_CLIP_SAT_EN
    localparam logic signed [IN_WIDTH:0] CLIP_MAX = (IN_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [IN_WIDTH:0] CLIP_MIN = ~CLIP_MAX;
`endif

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [N*OUT_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   last_q, last_d;
    logic                   sat_q, sat_d;

    logic                   capture;
    logic [N*OUT_WIDTH-1:0] f_data;
    logic                   sat_any;
    logic signed [IN_WIDTH:0] x_ext, sum;
    logic [OUT_WIDTH-1:0]   lane;
`ifdef ROUND_CLIP_SAT_EN
    logic signed [IN_WIDTH:0] t;
`endif

    // unload is the capture strobe itself, so the buffer never advances during a stall
    assign capture   = (state_q == S_DRAIN) && (!valid_q || out_ready);
    assign unload    = capture;
    assign blk_take  = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign out_sat   = sat_q;
    assign out_valid = valid_q;

    // Round-half-up then arithmetic shift, one extra bit so the offset cannot overflow
    always_comb begin
        f_data  = '0;
        sat_any = 1'b0;
        x_ext   = '0;
        sum     = '0;
        lane    = '0;
`ifdef ROUND_CLIP_SAT_EN
        t       = '0;
`endif
        for (int unsigned i = 0; i < N; i++) begin
            x_ext = (IN_WIDTH+1)'($signed(col_in[i*IN_WIDTH +: IN_WIDTH]));
            sum   = x_ext + RND;
`ifdef ROUND_CLIP_SAT_EN
            t = sum >>> SHIFT;
            if (t > CLIP_MAX) begin
                lane    = CLIP_MAX[OUT_WIDTH-1:0];
                sat_any = 1'b1;
            end else if (t < CLIP_MIN) begin
                lane    = CLIP_MIN[OUT_WIDTH-1:0];
                sat_any = 1'b1;
            end else begin
                lane = t[OUT_WIDTH-1:0];
            end
`else
            lane = OUT_WIDTH'(sum >>> SHIFT);
`endif
            f_data[i*OUT_WIDTH +: OUT_WIDTH] = lane;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        col_d   = col_q;
        last_d  = last_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (blk_full) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (capture) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            data_d  = f_data;
            col_d   = cnt_q;
            last_d  = (cnt_q == CNT_LAST);
            sat_d   = sat_any;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            col_q   <= col_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_dct_col_drain.sv
// Self-checking bench for dct_col_drain: buffer model, scoreboard, constant rounding/clip table.
module tb_dct_col_drain;
    localparam int N   = 32;
    localparam int IW  = 21;
    localparam int OW  = 16;
    localparam int OW8 = 8;
    localparam int CW  = 5;
    localparam int NT  = 16;

    typedef struct {
        int x;
        int e16;
        int e8s;
        int e8w;
    } vec_t;

    typedef struct {
        logic [N*OW-1:0] data;
        logic [CW-1:0]   col;
        logic            last;
        logic            sat;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, blk_full, blk_take, unload, out_last, out_sat, out_valid, out_ready;
    logic [N*IW-1:0]   col_in;
    logic [N*OW-1:0]   out_data;
    logic [CW-1:0]     out_col;

    logic              blk_full8, blk_take8, unload8, out_last8, out_sat8, out_valid8, out_ready8;
    logic [N*IW-1:0]   col8;
    logic [N*OW8-1:0]  out_data8;
    logic [CW-1:0]     out_col8;

    dct_col_drain #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(11), .N(N)) dut (
        .clk(clk), .rst(rst), .blk_full(blk_full), .blk_take(blk_take), .col_in(col_in),
        .unload(unload), .out_data(out_data), .out_col(out_col), .out_last(out_last),
        .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
    );

    dct_col_drain #(.IN_WIDTH(IW), .OUT_WIDTH(OW8), .SHIFT(11), .N(N)) dut8 (
        .clk(clk), .rst(rst), .blk_full(blk_full8), .blk_take(blk_take8), .col_in(col8),
        .unload(unload8), .out_data(out_data8), .out_col(out_col8), .out_last(out_last8),
        .out_sat(out_sat8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    vec_t               tbl [NT];
    logic signed [IW-1:0] blk [N][N];
    int                 exp_v [N][N];
    int unsigned        ptr;
    beat_t              q[$];
    int                 checks, failures, n_unload, n_beat, n_take, ustreak, take_streak;
    int                 u0, b0, t0;
    logic               stall_prev;
    beat_t              held;

    // Transpose-buffer model: shifts one column per unload, shares rst
    always @(posedge clk) begin
        if (rst) ptr <= 0;
        else if (unload) ptr <= (ptr + 1) % N;
    end

    always_comb begin
        col_in = '0;
        for (int i = 0; i < N; i++) col_in[i*IW +: IW] = blk[ptr][i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [N*OW-1:0] act, input logic [N*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                ustreak    = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chkv("stall_data", out_data, held.data);
                    chk("stall_col", 32'(out_col), 32'(held.col));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("beat_expected", 32'd0, 32'd1);
                    end else begin
                        e = q.pop_front();
                        chkv("beat_data", out_data, e.data);
                        chk("beat_col", 32'(out_col), 32'(e.col));
                        chk("beat_last", 32'(out_last), 32'(e.last));
                        chk("beat_sat", 32'(out_sat), 32'(e.sat));
                        n_beat++;
                    end
                end
                if (blk_take) begin
                    chk("take_no_unload", 32'(unload), 32'd0);
                    n_take++;
                    take_streak = ustreak;
                end
                if (unload) begin
                    e.data = '0;
                    for (int i = 0; i < N; i++) e.data[i*OW +: OW] = OW'(exp_v[ptr][i]);
                    e.col  = CW'(ptr);
                    e.last = (ptr == N - 1);
                    e.sat  = 1'b0;
                    q.push_back(e);
                    n_unload++;
                    ustreak++;
                end else begin
                    ustreak = 0;
                end
                stall_prev = out_valid && !out_ready;
                held.data  = out_data;
                held.col   = out_col;
            end
        end
    endtask

    // Value (k<<11)+lo wraps in 21 bits, so the expected output is k as a signed 10-bit number
    task automatic load_full(input bit rev);
        int k;
        for (int c = 0; c < N; c++)
            for (int i = 0; i < N; i++) begin
                k = rev ? 1023 - (32*c + i) : 32*c + i;
                blk[c][i]   = IW'((k << 11) + (rev ? 1023 : 0));
                exp_v[c][i] = (k < 512) ? k : k - 1024;
            end
    endtask

    task automatic load_table();
        for (int c = 0; c < N; c++)
            for (int i = 0; i < N; i++) begin
                blk[c][i]   = IW'(tbl[(c+i) % NT].x);
                exp_v[c][i] = tbl[(c+i) % NT].e16;
            end
    endtask

    task automatic begin_block();
        u0 = n_unload;
        b0 = n_beat;
        t0 = n_take;
    endtask

    task automatic finish_block(input string nm, input bit bp, input bit streak);
        int k;
        k = 0;
        while (n_take == t0 && k < 400) begin
            tick();
            if (bp) out_ready = ~out_ready;
            k++;
        end
        chk({nm, "_take_seen"}, 32'(n_take != t0), 32'd1);
        blk_full = 1'b0;
        k = 0;
        while ((q.size() != 0 || out_valid) && k < 200) begin
            tick();
            if (bp) out_ready = ~out_ready;
            k++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk({nm, "_unloads"}, 32'(n_unload - u0), 32'(N));
        chk({nm, "_beats"}, 32'(n_beat - b0), 32'(N));
        chk({nm, "_takes"}, 32'(n_take - t0), 32'd1);
        chk({nm, "_drained"}, 32'(q.size()), 32'd0);
        if (streak) chk({nm, "_streak"}, 32'(take_streak), 32'(N));
    endtask

    initial begin
        logic [N*OW8-1:0] exp8;
        logic             exp_sat8, seen8;
        int               k, nb, nu;

        tbl[0]  = '{1023, 0, 0, 0};
        tbl[1]  = '{1024, 1, 1, 1};
        tbl[2]  = '{-1024, 0, 0, 0};
        tbl[3]  = '{-1025, -1, -1, -1};
        tbl[4]  = '{3071, 1, 1, 1};
        tbl[5]  = '{1048575, 512, 127, 0};
        tbl[6]  = '{-1048576, -512, -128, 0};
        tbl[7]  = '{2047, 1, 1, 1};
        tbl[8]  = '{-2048, -1, -1, -1};
        tbl[9]  = '{131071, 64, 64, 64};
        tbl[10] = '{300000, 146, 127, -110};
        tbl[11] = '{-300000, -146, -128, 110};
        tbl[12] = '{259072, 127, 127, 127};
        tbl[13] = '{261120, 128, 127, -128};
        tbl[14] = '{-263168, -128, -128, -128};
        tbl[15] = '{-263169, -129, -128, 127};

        checks = 0; failures = 0; n_unload = 0; n_beat = 0; n_take = 0;
        ustreak = 0; take_streak = 0; stall_prev = 1'b0;
        u0 = 0; b0 = 0; t0 = 0;
        rst = 1'b1; blk_full = 1'b1; out_ready = 1'b1;
        blk_full8 = 1'b0; out_ready8 = 1'b1; col8 = '0;
        for (int c = 0; c < N; c++)
            for (int i = 0; i < N; i++) begin
                blk[c][i]   = IW'($urandom);
                exp_v[c][i] = 0;
            end
        fork
            monitor();
        join_none

        // Reset held with blk_full high and random column data
        for (int r = 0; r < 3; r++) begin
            tick();
            if (r == 2) load_full(1'b0);
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_unload", 32'(unload), 32'd0);
            chk("rst_take", 32'(blk_take), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
            chk("rst_sat", 32'(out_sat), 32'd0);
            chk("rst_col", 32'(out_col), 32'd0);
            chkv("rst_data", out_data, '0);
        end
        begin_block();
        rst = 1'b0;
        chk("idle_sample_unload", 32'(unload), 32'd0);
        @(negedge clk);
        chk("first_unload", 32'(unload), 32'd1);
        finish_block("full", 1'b0, 1'b1);

        load_table();
        begin_block();
        blk_full = 1'b1;
        finish_block("table", 1'b0, 1'b1);

        load_full(1'b1);
        begin_block();
        blk_full = 1'b1;
        finish_block("bp", 1'b1, 1'b0);

        // 8-bit instance: clip/wrap boundaries, same column every cycle
        exp8 = '0;
        for (int i = 0; i < N; i++) begin
            col8[i*IW +: IW] = IW'(tbl[i % NT].x);
`ifdef ROUND_CLIP_SAT_EN
            exp8[i*OW8 +: OW8] = OW8'(tbl[i % NT].e8s);
`else
            exp8[i*OW8 +: OW8] = OW8'(tbl[i % NT].e8w);
`endif
        end
`ifdef ROUND_CLIP_SAT_EN
        exp_sat8 = 1'b1;
`else
        exp_sat8 = 1'b0;
`endif
        blk_full8 = 1'b1;
        seen8 = 1'b0; nb = 0; nu = 0; k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (unload8) nu++;
            if (out_valid8 && !seen8) begin
                seen8 = 1'b1;
                chkv("sat8_data", {{(N*(OW-OW8)){1'b0}}, out_data8}, {{(N*(OW-OW8)){1'b0}}, exp8});
                chk("sat8_flag", 32'(out_sat8), 32'(exp_sat8));
            end
            if (out_valid8 && out_ready8) nb++;
            if (blk_take8) break;
        end
        chk("sat8_take", 32'(blk_take8), 32'd1);
        chk("sat8_last_at_take", 32'(out_last8), 32'd1);
        chk("sat8_col_at_take", 32'(out_col8), 32'(N - 1));
        tick();
        blk_full8 = 1'b0;
        chk("sat8_beats", 32'(nb), 32'(N));
        chk("sat8_unloads", 32'(nu), 32'(N));
        repeat (3) tick();

        // Reset after 10 beats abandons the block
        load_full(1'b0);
        begin_block();
        blk_full = 1'b1;
        k = 0;
        while (n_beat - b0 < 10 && k < 200) begin
            tick();
            k++;
        end
        chk("mid_beats_reached", 32'(n_beat - b0 >= 10), 32'd1);
        rst = 1'b1;
        blk_full = 1'b0;
        tick();
        q.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_unload", 32'(unload), 32'd0);
        chk("mid_rst_take", 32'(blk_take), 32'd0);
        chk("mid_rst_col", 32'(out_col), 32'd0);
        chkv("mid_rst_data", out_data, '0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("mid_idle_unload", 32'(unload), 32'd0);
            chk("mid_idle_take", 32'(blk_take), 32'd0);
        end
        chk("mid_no_take", 32'(n_take - t0), 32'd0);

        load_full(1'b1);
        tick();
        begin_block();
        blk_full = 1'b1;
        finish_block("fresh", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
